// File: rtl/debounce_multi.sv
// Multi-channel debouncer with press/release strobes; auto-repeat built only with DEBOUNCE_REPEAT_EN.
// Latency DELAY_COUNTS+3 cycles from first sample of a new stable level; no flow control, outputs are strobes.
// No backpressure: every channel runs freely each cycle and all outputs are registered.
module debounce_multi #(
  parameter int CHANNELS      = 4,
  parameter int DELAY_COUNTS  = 2500,
  parameter int HOLD_COUNTS   = 25000000,
  parameter int REPEAT_COUNTS = 5000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] button_pressed,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] repeat_pulse
);

  localparam int CW = $clog2(DELAY_COUNTS + 1);

  logic [CHANNELS-1:0] sync_meta;
  logic [CHANNELS-1:0] sync;
  logic [CHANNELS-1:0] prev;
  logic [CW-1:0]       cnt [CHANNELS];
  logic [CHANNELS-1:0] stable;
  logic [CHANNELS-1:0] fire;
  logic [CHANNELS-1:0] pressed_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= button;
      sync      <= sync_meta;
    end
  end

  // Counter saturates at DELAY_COUNTS so a long-held level never re-fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sync[i] != prev[i]) begin
          prev[i] <= sync[i];
          cnt[i]  <= '0;
        end else if (cnt[i] != CW'(DELAY_COUNTS)) begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    stable = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      stable[i] = (sync[i] == prev[i]) && (cnt[i] == CW'(DELAY_COUNTS));
    end
  end

  assign fire        = stable & (prev ^ button_pressed);
  assign pressed_nxt = (fire & prev) | (~fire & button_pressed);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      button_pressed <= '0;
      press_pulse    <= '0;
      release_pulse  <= '0;
    end else begin
      button_pressed <= pressed_nxt;
      press_pulse    <= fire & prev;
      release_pulse  <= fire & ~prev;
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;
  localparam int HMAX = (HOLD_COUNTS > REPEAT_COUNTS) ? HOLD_COUNTS : REPEAT_COUNTS;
  localparam int HW   = $clog2(HMAX + 1);

  logic [1:0]    state [CHANNELS];
  logic [HW-1:0] hcnt  [CHANNELS];

  // Looking at the next debounced level lets a release win over a coincident repeat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      repeat_pulse <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state[i] <= ST_IDLE;
        hcnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        repeat_pulse[i] <= 1'b0;
        if (!pressed_nxt[i]) begin
          state[i] <= ST_IDLE;
          hcnt[i]  <= '0;
        end else begin
          case (state[i])
            ST_IDLE: begin
              if (fire[i]) begin
                state[i] <= ST_HOLD;
                hcnt[i]  <= '0;
              end
            end
            ST_HOLD: begin
              if (hcnt[i] == HW'(HOLD_COUNTS - 1)) begin
                repeat_pulse[i] <= 1'b1;
                hcnt[i]         <= '0;
                state[i]        <= ST_REPEAT;
              end else begin
                hcnt[i] <= hcnt[i] + HW'(1);
              end
            end
            ST_REPEAT: begin
              if (hcnt[i] == HW'(REPEAT_COUNTS - 1)) begin
                repeat_pulse[i] <= 1'b1;
                hcnt[i]         <= '0;
              end else begin
                hcnt[i] <= hcnt[i] + HW'(1);
              end
            end
            default: begin
              state[i] <= ST_IDLE;
              hcnt[i]  <= '0;
            end
          endcase
        end
      end
    end
  end
`else
  // Repeat timing parameters have no effect in this build.
  logic unused_cfg;
  assign unused_cfg   = (HOLD_COUNTS > 0) ^ (REPEAT_COUNTS > 0);
  assign repeat_pulse = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Randomized and directed bench for debounce_multi against a sample-history reference model.
module tb_debounce_multi;

  localparam int CH = 4;
  localparam int D  = 4;
  localparam int H  = 10;
  localparam int R  = 4;
  localparam int HL = D + 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CH-1:0] button = '0;
  logic [CH-1:0] button_pressed;
  logic [CH-1:0] press_pulse;
  logic [CH-1:0] release_pulse;
  logic [CH-1:0] repeat_pulse;

  always #5 clk = ~clk;

  debounce_multi #(
    .CHANNELS(CH),
    .DELAY_COUNTS(D),
    .HOLD_COUNTS(H),
    .REPEAT_COUNTS(R)
  ) dut (
    .clk(clk),
    .rst(rst),
    .button(button),
    .button_pressed(button_pressed),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: a new level is accepted once D+2 consecutive raw samples, seen
  // two edges late through the synchroniser, agree and differ from the current level.
  bit            hist [CH][HL];
  int            age  [CH];
  logic [CH-1:0] exp_bp    = '0;
  logic [CH-1:0] exp_press = '0;
  logic [CH-1:0] exp_rel   = '0;
  logic [CH-1:0] exp_rep   = '0;

  int first_press [CH];
  int first_rel   [CH];
  int press_cnt   [CH];
  int rel_cnt     [CH];
  int rep_cnt     [CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_bp    = '0;
    exp_press = '0;
    exp_rel   = '0;
    exp_rep   = '0;
    for (int c = 0; c < CH; c++) begin
      age[c] = 0;
      for (int j = 0; j < HL; j++) hist[c][j] = 1'b0;
    end
  endtask

  task automatic model_update();
    bit all_eq;
    if (rst) begin
      model_reset();
    end else begin
      for (int c = 0; c < CH; c++) begin
        for (int j = HL - 1; j > 0; j--) hist[c][j] = hist[c][j-1];
        hist[c][0] = button[c];
        all_eq = 1'b1;
        for (int j = 3; j < HL; j++) if (hist[c][j] != hist[c][2]) all_eq = 1'b0;
        exp_press[c] = 1'b0;
        exp_rel[c]   = 1'b0;
        exp_rep[c]   = 1'b0;
        if (all_eq && (hist[c][2] != exp_bp[c])) begin
          exp_bp[c]    = hist[c][2];
          exp_press[c] = hist[c][2];
          exp_rel[c]   = !hist[c][2];
          age[c]       = 0;
        end else if (exp_bp[c]) begin
          age[c]++;
`ifdef DEBOUNCE_REPEAT_EN
          if (age[c] >= H && ((age[c] - H) % R) == 0) exp_rep[c] = 1'b1;
`endif
        end
      end
    end
  endtask

  task automatic clear_stats();
    for (int c = 0; c < CH; c++) begin
      first_press[c] = -1;
      first_rel[c]   = -1;
      press_cnt[c]   = 0;
      rel_cnt[c]     = 0;
      rep_cnt[c]     = 0;
    end
  endtask

  task automatic check_outputs();
    check("button_pressed", 32'(button_pressed), 32'(exp_bp));
    check("press_pulse", 32'(press_pulse), 32'(exp_press));
    check("release_pulse", 32'(release_pulse), 32'(exp_rel));
    check("repeat_pulse", 32'(repeat_pulse), 32'(exp_rep));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    cyc++;
    check_outputs();
    for (int c = 0; c < CH; c++) begin
      if (press_pulse[c]) begin
        press_cnt[c]++;
        if (first_press[c] < 0) first_press[c] = cyc;
      end
      if (release_pulse[c]) begin
        rel_cnt[c]++;
        if (first_rel[c] < 0) first_rel[c] = cyc;
      end
      if (repeat_pulse[c]) rep_cnt[c]++;
    end
  endtask

  initial begin
    int c0;
    int run_left [CH];
    clear_stats();
    model_reset();

    // Asynchronous reset between edges, then idle
    #3 rst = 1'b1;
    #1 check_outputs();
    step();
    step();
    rst = 1'b0;
    repeat (10) step();

    // Clean press and release on channel 0
    clear_stats();
    button[0] = 1'b1;
    step();
    c0 = cyc;
    repeat (12) step();
    check("press_latency0", 32'(first_press[0] - c0), 32'(D + 3));
    check("press_count0", 32'(press_cnt[0]), 32'd1);
    clear_stats();
    button[0] = 1'b0;
    step();
    c0 = cyc;
    repeat (12) step();
    check("release_latency0", 32'(first_rel[0] - c0), 32'(D + 3));

    // Bouncing channel 1: 3 high / 2 low, then held
    clear_stats();
    for (int k = 0; k < 40; k++) begin
      button[1] = ((k % 5) < 3);
      step();
    end
    button[1] = 1'b1;
    repeat (15) step();
    check("bounce_press_count1", 32'(press_cnt[1]), 32'd1);
    button[1] = 1'b0;
    repeat (12) step();

    // Channels 0 and 3 together, channel 3 bounces once
    clear_stats();
    button[0] = 1'b1;
    button[3] = 1'b1;
    step();
    button[3] = 1'b0;
    step();
    button[3] = 1'b1;
    repeat (14) step();
    check("skew_ch3_vs_ch0", 32'(first_press[3] - first_press[0]), 32'd2);
    check("press_count3", 32'(press_cnt[3]), 32'd1);
    button[0] = 1'b0;
    button[3] = 1'b0;
    repeat (12) step();

    // Auto-repeat on channel 2; release lands on a repeat slot
    clear_stats();
    button[2] = 1'b1;
    repeat (42) step();
    button[2] = 1'b0;
    repeat (15) step();
`ifdef DEBOUNCE_REPEAT_EN
    check("repeat_count2", 32'(rep_cnt[2]), 32'd8);
`else
    check("repeat_count2", 32'(rep_cnt[2]), 32'd0);
`endif
    check("release_count2", 32'(rel_cnt[2]), 32'd1);

    // Reset while channel 0 is held
    button[0] = 1'b1;
    repeat (15) step();
    clear_stats();
    #3 rst = 1'b1;
    model_reset();
    #1 check_outputs();
    step();
    rst = 1'b0;
    step();
    c0 = cyc;
    repeat (12) step();
    check("post_reset_press0", 32'(first_press[0] - c0), 32'(D + 3));
    check("post_reset_release0", 32'(rel_cnt[0]), 32'd0);
    button[0] = 1'b0;
    repeat (12) step();

    // Random runs per channel
    for (int c = 0; c < CH; c++) run_left[c] = 0;
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < CH; c++) begin
        if (run_left[c] == 0) begin
          button[c]   = 1'($urandom_range(0, 1));
          run_left[c] = $urandom_range(1, 10);
        end
        run_left[c]--;
      end
      step();
    end
    button = '0;
    repeat (15) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
